// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one 16-bit word request at a time, WAIT_CYCLES
// wait states, then a single-cycle response pulse with registered data/error/we.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_we,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_s;
  logic [3:0]          cnt_r;
  logic                we_r;
  logic [15:0]         addr_r;
  logic [15:0]         wdata_r;
  logic                rsp_valid_r;
  logic [15:0]         rdata_r;
  logic                err_r;
  logic                rsp_we_r;
  logic [15:0]         mem_r [DEPTH];

  logic                load_s;
  logic                access_s;
  logic                acc_we_s;
  logic [15:0]         acc_addr_s;
  logic [15:0]         acc_wdata_s;
  logic                in_range_s;
  logic [ADDR_W-1:0]   idx_s;

  // Next-state decode; the access strobe fires on the edge that leaves for RESP.
  always_comb begin
    next_s   = state_r;
    load_s   = 1'b0;
    access_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          load_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_s   = ST_RESP;
            access_s = 1'b1;
          end else begin
            next_s = ST_WAIT;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          next_s   = ST_RESP;
          access_s = 1'b1;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Zero-wait accesses use the live inputs on the acceptance edge, otherwise the held copy.
  always_comb begin
    acc_we_s    = (state_r == ST_IDLE) ? req_we    : we_r;
    acc_addr_s  = (state_r == ST_IDLE) ? req_addr  : addr_r;
    acc_wdata_s = (state_r == ST_IDLE) ? req_wdata : wdata_r;
    in_range_s  = ((acc_addr_s >> ADDR_W) == 16'd0);
    idx_s       = acc_addr_s[ADDR_W-1:0];
  end

  // Control state, holding registers and registered response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      addr_r      <= 16'd0;
      wdata_r     <= 16'd0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= 16'd0;
      err_r       <= 1'b0;
      rsp_we_r    <= 1'b0;
    end else begin
      state_r     <= next_s;
      rsp_valid_r <= (next_s == ST_RESP);
      if (load_s) begin
        we_r    <= req_we;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        cnt_r   <= CNT_INIT;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (access_s) begin
        rsp_we_r <= acc_we_s;
        err_r    <= ~in_range_s;
        rdata_r  <= (!acc_we_s && in_range_s) ? mem_r[idx_s] : 16'd0;
      end
    end
  end

  // Backing array; reset wipes every word so abandoned stores leave no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'd0;
      end
    end else if (access_s && acc_we_s && in_range_s) begin
      mem_r[idx_s] <= acc_wdata_s;
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign rsp_we    = rsp_we_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: two responders (WAIT_CYCLES 2 and 0) against a
// word-array reference model with expected latency computed from the wait count.
module tb_dmem_responder;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        rsp_we    [2];
  logic        busy      [2];

  int          errors;
  int          checks;
  int          cyc;
  int          wait_of [2];
  logic [15:0] mem_m   [2][256];

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .rsp_we(rsp_we[0]), .busy(busy[0])
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .rsp_we(rsp_we[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction; the acceptance edge counts as edge 1, so the response should
  // be seen after edge WAIT_CYCLES+1. With noise the request lines keep toggling.
  task automatic xact(input int d, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input bit noise, output int acc_cyc);
    int          edges;
    bit          got;
    logic        exp_err;
    logic [15:0] exp_rd;
    exp_err = (addr >= 16'd256);
    exp_rd  = (we || exp_err) ? 16'd0 : mem_m[d][addr[7:0]];
    @(negedge clk);
    check_eq("ready_before_req", {31'd0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk); #1;
    acc_cyc = cyc;
    edges   = 1;
    got     = 1'b0;
    while (!got && edges < 40) begin
      if (noise) begin
        req_we[d]    = 1'b1;
        req_addr[d]  = 16'($urandom_range(0, 15));
        req_wdata[d] = 16'($urandom);
      end else begin
        req_valid[d] = 1'b0;
      end
      if (rsp_valid[d]) begin
        got = 1'b1;
      end else begin
        check_eq("busy_in_wait", {31'd0, busy[d]}, 32'd1);
        check_eq("ready_in_wait", {31'd0, req_ready[d]}, 32'd0);
        @(posedge clk); #1;
        edges++;
      end
    end
    check_eq("rsp_seen", {31'd0, got}, 32'd1);
    check_eq("latency_edges", edges, wait_of[d] + 1);
    check_eq("rsp_we", {31'd0, rsp_we[d]}, {31'd0, we});
    check_eq("rsp_err", {31'd0, rsp_err[d]}, {31'd0, exp_err});
    check_eq("rsp_rdata", {16'd0, rsp_rdata[d]}, {16'd0, exp_rd});
    check_eq("busy_in_resp", {31'd0, busy[d]}, 32'd1);
    check_eq("ready_in_resp", {31'd0, req_ready[d]}, 32'd0);
    if (we && !exp_err) mem_m[d][addr[7:0]] = wdata;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    check_eq("rsp_single_pulse", {31'd0, rsp_valid[d]}, 32'd0);
    check_eq("ready_after_resp", {31'd0, req_ready[d]}, 32'd1);
    check_eq("busy_after_resp", {31'd0, busy[d]}, 32'd0);
  endtask

  initial begin
    int a0;
    int a1;
    int dd;
    logic [15:0] ra;
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    wait_of[0] = 2;
    wait_of[1] = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mem_m[d][i] = 16'd0;
      rst[d]       = 1'b1;
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = 16'h0005;
      req_wdata[d] = 16'hFFFF;
    end

    // Reset held two edges with a request pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b0;
      req_valid[d] = 1'b0;
      check_eq("rst_ready", {31'd0, req_ready[d]}, 32'd1);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      check_eq("rst_rdata", {16'd0, rsp_rdata[d]}, 32'd0);
      check_eq("rst_err", {31'd0, rsp_err[d]}, 32'd0);
      check_eq("rst_we", {31'd0, rsp_we[d]}, 32'd0);
      check_eq("rst_busy", {31'd0, busy[d]}, 32'd0);
    end
    xact(0, 1'b0, 16'h0005, 16'h0000, 1'b0, a0);

    // Store then load, two wait states
    xact(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, a0);
    xact(0, 1'b0, 16'h0010, 16'h0000, 1'b0, a0);

    // Busy window: lines keep changing, only the first request is serviced
    xact(0, 1'b1, 16'h0020, 16'hCAFE, 1'b1, a0);
    xact(0, 1'b0, 16'h0020, 16'h0000, 1'b0, a1);
    check_eq("accept_spacing_w2", a1 - a0, 4);
    for (int i = 0; i < 16; i++) xact(0, 1'b0, 16'(i), 16'h0000, 1'b0, a0);

    // Out of range
    xact(0, 1'b1, 16'h0100, 16'h1234, 1'b0, a0);
    xact(0, 1'b0, 16'h0000, 16'h0000, 1'b0, a0);
    xact(0, 1'b0, 16'h0100, 16'h0000, 1'b0, a0);

    // Zero wait states, back to back
    xact(1, 1'b1, 16'h0001, 16'h00AA, 1'b0, a0);
    xact(1, 1'b0, 16'h0001, 16'h0000, 1'b0, a1);
    check_eq("accept_spacing_w0", a1 - a0, 2);

    // Reset during WAIT abandons the store
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 16'h0003;
    req_wdata[0] = 16'h5555;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check_eq("midop_busy", {31'd0, busy[0]}, 32'd1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check_eq("midop_ready", {31'd0, req_ready[0]}, 32'd1);
    for (int i = 0; i < 256; i++) mem_m[0][i] = 16'd0;
    for (int i = 0; i < 5; i++) begin
      check_eq("midop_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
      @(posedge clk); #1;
    end
    xact(0, 1'b0, 16'h0003, 16'h0000, 1'b0, a0);
    xact(0, 1'b0, 16'h0010, 16'h0000, 1'b0, a0);

    // Randomized traffic over a small hot set plus occasional out-of-range addresses
    for (int n = 0; n < 80; n++) begin
      dd = int'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                       : 16'($urandom_range(0, 15));
      xact(dd, 1'($urandom_range(0, 1)), ra, 16'($urandom), 1'($urandom_range(0, 1)), a0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
